// File: rtl/halfword_mem_unit.sv
// Halfword load/store engine: LHU/LH/SH against a 32-bit word memory.
// Stores are read-modify-write; all bus waits are bounded by ACK_TIMEOUT.
module halfword_mem_unit #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        addr_err,
  output logic        bus_err,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack
);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } state_t;

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  state_t        state, nxt;
  logic [1:0]    op_q;
  logic [31:1]   addr_q;
  logic [15:0]   wdata_q;
  logic [31:0]   merged;
  logic [CW-1:0] cnt;
  logic          aerr_q, berr_q;
  logic [15:0]   half;
  logic          bad, tmo, is_sh;

  assign half  = addr_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
  assign bad   = addr[0] | (op == 2'b11);
  assign is_sh = (op_q == 2'b10);
  assign tmo   = !dm_ack && (cnt == CW'(ACK_TIMEOUT - 1));

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (start) nxt = bad ? DONE : RD;
      RD: begin
        if (dm_ack)   nxt = is_sh ? WR : DONE;
        else if (tmo) nxt = DONE;
      end
      WR:   if (dm_ack || tmo) nxt = DONE;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      merged  <= '0;
      rdata   <= '0;
      cnt     <= '0;
      aerr_q  <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          op_q    <= op;
          addr_q  <= addr[31:1];
          wdata_q <= wdata[15:0];
          aerr_q  <= bad;
          berr_q  <= 1'b0;
          cnt     <= '0;
        end
        RD: begin
          if (dm_ack) begin
            cnt <= '0;
            if (is_sh)
              merged <= addr_q[1] ? {wdata_q, dm_rdata[15:0]}
                                  : {dm_rdata[31:16], wdata_q};
            else if (op_q[0])
              rdata <= {{16{half[15]}}, half};
            else
              rdata <= {16'h0000, half};
          end else if (tmo) begin
            berr_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WR: begin
          if (!dm_ack) begin
            if (tmo) berr_q <= 1'b1;
            else     cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign dm_req   = (state == RD) || (state == WR);
  assign dm_we    = (state == WR);
  assign dm_addr  = {addr_q[31:2], 2'b00};
  assign dm_wdata = merged;
  assign addr_err = done & aerr_q;
  assign bus_err  = done & berr_q;

endmodule

// File: tb/tb_halfword_mem_unit.sv
// Directed bench for halfword_mem_unit with a small memory responder
// whose ack delay and enable are set per scenario.
module tb_halfword_mem_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        busy, done, addr_err, bus_err;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem;
  int          ack_delay = 0;
  bit          ack_en = 1'b1;
  int          wcnt = 0;
  bit          ack_taken = 1'b0;
  int          writes = 0;
  logic [31:0] waddr, wword, raddr;

  halfword_mem_unit #(.ACK_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .addr(addr), .wdata(wdata), .rdata(rdata),
    .busy(busy), .done(done), .addr_err(addr_err),
    .bus_err(bus_err), .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack)
  );

  always #5 clk = ~clk;

  assign dm_rdata = mem;

  always @(posedge clk) begin
    if (!rst && dm_req && dm_ack) begin
      ack_taken = 1'b1;
      if (dm_we) begin
        writes = writes + 1;
        waddr  = dm_addr;
        wword  = dm_wdata;
        mem    = dm_wdata;
      end else begin
        raddr = dm_addr;
      end
    end
  end

  always @(negedge clk) begin
    if (rst || !dm_req) begin
      dm_ack    = 1'b0;
      wcnt      = 0;
      ack_taken = 1'b0;
    end else begin
      if (ack_taken) wcnt = 0;
      ack_taken = 1'b0;
      if (ack_en && wcnt >= ack_delay) begin
        dm_ack = 1'b1;
      end else begin
        dm_ack = 1'b0;
        wcnt   = wcnt + 1;
      end
    end
  end

  // Issues one request, scrambles the inputs after the start edge,
  // and reports the cycle (start edge = 0) in which done was seen.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] d, input bit poke_done,
                        output int cyc, output int reqs,
                        output logic aerr, output logic berr);
    @(negedge clk);
    start = 1'b1; op = o; addr = a; wdata = d;
    @(posedge clk); #1;
    start = 1'b0; op = 2'b11; addr = 32'hFFFF_FFFF; wdata = '0;
    cyc = 1; reqs = 0; aerr = 1'b0; berr = 1'b0;
    while (cyc < 300) begin
      if (dm_req) reqs++;
      if (done) break;
      @(posedge clk); #1;
      cyc++;
    end
    aerr = addr_err; berr = bus_err;
    if (poke_done) begin
      start = 1'b1; op = 2'b00; addr = 32'h1000_0000;
    end
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || addr_err !== 1'b0) begin
      $display("FAIL after_done: done=%b busy=%b aerr=%b want 0 0 0",
               done, busy, addr_err);
      errors++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; op = 0; addr = 0; wdata = 0;
    mem = 32'h0; dm_ack = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({rdata, busy, done, addr_err, bus_err, dm_req, dm_we} !== '0
        || dm_addr !== 0 || dm_wdata !== 0) begin
      $display("FAIL reset_outputs: rdata=%h busy=%b done=%b req=%b",
               rdata, busy, done, dm_req);
      errors++;
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_loads();
    int cyc, reqs;
    logic ae, be;
    mem = 32'h8001_7FFF; ack_delay = 0; ack_en = 1;
    run_op(2'b00, 32'h1000_0002, 0, 0, cyc, reqs, ae, be);
    checks++;
    if (rdata !== 32'h0000_8001 || cyc != 2 || ae || be) begin
      $display("FAIL lhu_hi: rdata=%h cyc=%0d ae=%b be=%b want 00008001 2 0 0",
               rdata, cyc, ae, be);
      errors++;
    end
    checks++;
    if (raddr !== 32'h1000_0000) begin
      $display("FAIL lhu_addr: dm_addr=%h want 10000000", raddr);
      errors++;
    end
    run_op(2'b01, 32'h1000_0002, 0, 0, cyc, reqs, ae, be);
    checks++;
    if (rdata !== 32'hFFFF_8001 || cyc != 2) begin
      $display("FAIL lh_hi: rdata=%h cyc=%0d want ffff8001 2", rdata, cyc);
      errors++;
    end
    run_op(2'b01, 32'h1000_0000, 0, 0, cyc, reqs, ae, be);
    checks++;
    if (rdata !== 32'h0000_7FFF) begin
      $display("FAIL lh_lo: rdata=%h want 00007fff", rdata);
      errors++;
    end
    ack_delay = 1;
    run_op(2'b00, 32'h2000_0000, 0, 0, cyc, reqs, ae, be);
    checks++;
    if (rdata !== 32'h0000_7FFF || cyc != 3) begin
      $display("FAIL lhu_lo_wait: rdata=%h cyc=%0d want 00007fff 3",
               rdata, cyc);
      errors++;
    end
  endtask

  task automatic test_store();
    int cyc, reqs, w0;
    logic ae, be;
    mem = 32'h1122_3344; ack_delay = 2; w0 = writes;
    run_op(2'b10, 32'h1000_0002, 32'hDEAD_BEEF, 0, cyc, reqs, ae, be);
    checks++;
    if (writes - w0 != 1 || waddr !== 32'h1000_0000
        || wword !== 32'hBEEF_3344) begin
      $display("FAIL sh_hi: writes=%0d addr=%h data=%h want 1 10000000 beef3344",
               writes - w0, waddr, wword);
      errors++;
    end
    checks++;
    if (cyc != 7 || ae || be || rdata !== 32'h0000_7FFF) begin
      $display("FAIL sh_hi_done: cyc=%0d ae=%b be=%b rdata=%h want 7 0 0 00007fff",
               cyc, ae, be, rdata);
      errors++;
    end
    ack_delay = 0; w0 = writes;
    run_op(2'b10, 32'h1000_0000, 32'h1234_CAFE, 0, cyc, reqs, ae, be);
    checks++;
    if (writes - w0 != 1 || wword !== 32'hBEEF_CAFE || cyc != 3) begin
      $display("FAIL sh_lo: writes=%0d data=%h cyc=%0d want 1 beefcafe 3",
               writes - w0, wword, cyc);
      errors++;
    end
  endtask

  task automatic test_addr_err();
    int cyc, reqs;
    logic ae, be;
    run_op(2'b01, 32'h1000_0001, 0, 0, cyc, reqs, ae, be);
    checks++;
    if (cyc != 1 || !ae || be || reqs != 0 || rdata !== 32'h0000_7FFF) begin
      $display("FAIL misaligned: cyc=%0d ae=%b be=%b reqs=%0d rdata=%h want 1 1 0 0 00007fff",
               cyc, ae, be, reqs, rdata);
      errors++;
    end
    run_op(2'b11, 32'h1000_0000, 0, 0, cyc, reqs, ae, be);
    checks++;
    if (cyc != 1 || !ae || be || reqs != 0 || rdata !== 32'h0000_7FFF) begin
      $display("FAIL op_rsvd: cyc=%0d ae=%b be=%b reqs=%0d rdata=%h want 1 1 0 0 00007fff",
               cyc, ae, be, reqs, rdata);
      errors++;
    end
  endtask

  task automatic test_timeout();
    int cyc, reqs, w0;
    logic ae, be;
    ack_en = 0; w0 = writes;
    run_op(2'b10, 32'h1000_0002, 32'h0000_5555, 0, cyc, reqs, ae, be);
    checks++;
    if (reqs != 8 || cyc != 9 || !be || ae) begin
      $display("FAIL timeout: reqs=%0d cyc=%0d be=%b ae=%b want 8 9 1 0",
               reqs, cyc, be, ae);
      errors++;
    end
    checks++;
    if (writes != w0 || rdata !== 32'h0000_7FFF) begin
      $display("FAIL timeout_side: writes=%0d rdata=%h want 0 00007fff",
               writes - w0, rdata);
      errors++;
    end
    ack_en = 1;
  endtask

  task automatic test_back_to_back();
    int cyc, reqs;
    logic ae, be;
    mem = 32'hA5A5_0F0F; ack_delay = 0;
    run_op(2'b00, 32'h3000_0000, 0, 1, cyc, reqs, ae, be);
    checks++;
    if (rdata !== 32'h0000_0F0F || cyc != 2) begin
      $display("FAIL start_in_done: rdata=%h cyc=%0d want 00000f0f 2",
               rdata, cyc);
      errors++;
    end
  endtask

  task automatic test_reset_mid_wr();
    int n, cyc, reqs, w0;
    logic ae, be;
    mem = 32'h0000_0000; ack_delay = 3; w0 = writes;
    @(negedge clk);
    start = 1'b1; op = 2'b10; addr = 32'h1000_0000; wdata = 32'h7777;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!dm_we && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!dm_we) begin
      $display("FAIL reach_wr: dm_we=%b want 1", dm_we);
      errors++;
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (dm_req !== 0 || dm_we !== 0 || busy !== 0 || rdata !== 0
        || dm_wdata !== 0 || dm_addr !== 0 || writes != w0) begin
      $display("FAIL rst_mid_wr: req=%b busy=%b rdata=%h wd=%h writes=%0d want all 0",
               dm_req, busy, rdata, dm_wdata, writes - w0);
      errors++;
    end
    @(negedge clk);
    rst = 1'b0;
    mem = 32'hC001_0002; ack_delay = 0;
    run_op(2'b01, 32'h1000_0002, 0, 0, cyc, reqs, ae, be);
    checks++;
    if (rdata !== 32'hFFFF_C001 || cyc != 2 || ae || be) begin
      $display("FAIL after_rst: rdata=%h cyc=%0d want ffffc001 2",
               rdata, cyc);
      errors++;
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_store();
    test_addr_err();
    test_timeout();
    test_back_to_back();
    test_reset_mid_wr();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
